// File: rtl/d3s_tune_scheduler.sv
// Time-triggered DDS tune command scheduler: FWFT command queue released on
// the WR reference cycle matching each command's {TAI, cycles} timestamp.
//
// state | meaning
// IDLE  | queue empty, nothing to compare
// ARMED | head command compared against WR time every cycle
// HOLD  | WR time invalid, compare and late detection suspended
module d3s_tune_scheduler #(
    parameter int g_fifo_depth     = 8,
    parameter int g_cycles_per_sec = 125000000,
    parameter int g_late_policy    = 0
) (
    input  logic                          clk_ref_i,
    input  logic                          rst_i,
    input  logic                          tm_time_valid_i,
    input  logic [39:0]                   tm_tai_i,
    input  logic [27:0]                   tm_cycles_i,
    input  logic                          cmd_valid_i,
    output logic                          cmd_ready_o,
    input  logic [39:0]                   cmd_tai_i,
    input  logic [27:0]                   cmd_cycles_i,
    input  logic [15:0]                   cmd_tune_i,
    input  logic                          cmd_load_acc_i,
    input  logic [47:0]                   cmd_acc_i,
    input  logic                          flush_i,
    output logic                          tune_stb_o,
    output logic [15:0]                   tune_val_o,
    output logic                          tune_load_acc_o,
    output logic [47:0]                   tune_acc_o,
    output logic                          late_o,
    output logic                          reject_o,
    output logic [15:0]                   late_cnt_o,
    output logic [$clog2(g_fifo_depth):0] level_o
);

    localparam int              c_aw    = $clog2(g_fifo_depth);
    localparam logic [c_aw:0]   c_depth = g_fifo_depth[c_aw:0];
    localparam logic [27:0]     c_cps   = g_cycles_per_sec[27:0];
    localparam logic            c_issue_late = (g_late_policy != 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ARMED = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    typedef struct packed {
        logic [39:0] tai;
        logic [27:0] cyc;
        logic [15:0] tune;
        logic        load_acc;
        logic [47:0] acc;
    } cmd_t;

    cmd_t            mem_q [g_fifo_depth];
    logic [c_aw-1:0] wr_ptr_q, rd_ptr_q;
    logic [c_aw:0]   level_q;
    state_t          state_q, state_d;

    logic            tune_stb_q;
    logic [15:0]     tune_val_q;
    logic            tune_load_acc_q;
    logic [47:0]     tune_acc_q;
    logic            late_q;
    logic            reject_q;
    logic [15:0]     late_cnt_q;

    logic            push_req, push, reject_d;
    logic            pop, issue, late;
    cmd_t            head;
    logic [67:0]     now_time, head_time;

    assign cmd_ready_o = (level_q < c_depth);
    // A push that lands on a flush edge is dropped outright, so it cannot reject either.
    assign push_req    = cmd_valid_i && cmd_ready_o && !flush_i;
    assign push        = push_req && (cmd_cycles_i < c_cps);
    assign reject_d    = push_req && (cmd_cycles_i >= c_cps);

    assign head      = mem_q[rd_ptr_q];
    assign now_time  = {tm_tai_i, tm_cycles_i};
    assign head_time = {head.tai, head.cyc};

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        issue   = 1'b0;
        late    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (push) state_d = S_ARMED;
            end
            S_ARMED: begin
                if (!tm_time_valid_i) begin
                    state_d = S_HOLD;
                end else if (now_time == head_time) begin
                    issue = 1'b1;
                    pop   = 1'b1;
                end else if (now_time > head_time) begin
                    late  = 1'b1;
                    pop   = 1'b1;
                    issue = c_issue_late;
                end
                if (pop && (level_q == 1) && !push) state_d = S_IDLE;
            end
            S_HOLD: begin
                if (tm_time_valid_i) state_d = S_ARMED;
            end
            default: state_d = S_IDLE;
        endcase
        if (flush_i) begin
            state_d = S_IDLE;
            pop     = 1'b0;
            issue   = 1'b0;
            late    = 1'b0;
        end
    end

    always_ff @(posedge clk_ref_i) begin
        if (!rst_i && push) mem_q[wr_ptr_q] <= '{cmd_tai_i, cmd_cycles_i, cmd_tune_i,
                                                 cmd_load_acc_i, cmd_acc_i};
    end

    always_ff @(posedge clk_ref_i) begin
        if (rst_i) begin
            state_q         <= S_IDLE;
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            level_q         <= '0;
            tune_stb_q      <= 1'b0;
            tune_val_q      <= '0;
            tune_load_acc_q <= 1'b0;
            tune_acc_q      <= '0;
            late_q          <= 1'b0;
            reject_q        <= 1'b0;
            late_cnt_q      <= '0;
        end else begin
            state_q <= state_d;
            if (flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                level_q  <= '0;
            end else begin
                if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
                case ({push, pop})
                    2'b10:   level_q <= level_q + 1'b1;
                    2'b01:   level_q <= level_q - 1'b1;
                    default: level_q <= level_q;
                endcase
            end
            tune_stb_q <= issue;
            if (issue) begin
                tune_val_q      <= head.tune;
                tune_load_acc_q <= head.load_acc;
                tune_acc_q      <= head.acc;
            end
            late_q   <= late;
            reject_q <= reject_d;
            if (late && (late_cnt_q != 16'hFFFF)) late_cnt_q <= late_cnt_q + 1'b1;
        end
    end

    assign tune_stb_o      = tune_stb_q;
    assign tune_val_o      = tune_val_q;
    assign tune_load_acc_o = tune_load_acc_q;
    assign tune_acc_o      = tune_acc_q;
    assign late_o          = late_q;
    assign reject_o        = reject_q;
    assign late_cnt_o      = late_cnt_q;
    assign level_o         = level_q;

endmodule

// File: doc/d3s_tune_scheduler.md
Name: d3s_tune_scheduler

Overview:
- Time-triggered command scheduler for the D3S DDS tuning path.
- The host pushes timestamped tune/accumulator-load commands (WR TAI + cycles) into a small first-word-fall-through (FWFT) queue.
- The block releases each command to the DDS tune interface exactly on the WR reference cycle that matches its timestamp.
- Sits between the CSR/mqueue command path and the DDS tune register logic, in the clk_ref_i domain, fed by the WR timing inputs.

Parameters:
- g_fifo_depth, 8: command queue depth; power of two, 2..64.
- g_cycles_per_sec, 125000000: tm_cycles_i wrap value. Use 1250 in simulation.
- g_late_policy, 0: 0 = drop late commands; 1 = issue late commands immediately.

Ports:
- clk_ref_i, in, 1: WR reference clock. The only clock.
- rst_i, in, 1: synchronous reset, active-high.
- tm_time_valid_i, in, 1: WR time valid.
- tm_tai_i, in, 40: current TAI seconds.
- tm_cycles_i, in, 28: current cycle within the second.
- cmd_valid_i, in, 1: command push request.
- cmd_ready_o, out, 1: queue not full.
- cmd_tai_i, in, 40: target TAI.
- cmd_cycles_i, in, 28: target cycle.
- cmd_tune_i, in, 16: signed tune value.
- cmd_load_acc_i, in, 1: also load the accumulator.
- cmd_acc_i, in, 48: accumulator load value.
- flush_i, in, 1: discard all queued and armed commands.
- tune_stb_o, out, 1: one-cycle issue strobe.
- tune_val_o, out, 16: issued tune value.
- tune_load_acc_o, out, 1: issued load flag.
- tune_acc_o, out, 48: issued accumulator value.
- late_o, out, 1: one-cycle pulse when a command is detected late.
- reject_o, out, 1: one-cycle pulse when a push is rejected.
- late_cnt_o, out, 16: saturating late counter.
- level_o, out, log2(g_fifo_depth)+1: queue occupancy.

Behaviour:
- Reset (synchronous, rst_i=1 at an edge):
  - Queue emptied; state IDLE.
  - All outputs are 0 except cmd_ready_o=1.
  - late_cnt_o is cleared.
- Push:
  - A push is accepted at an edge where cmd_valid_i=1 and cmd_ready_o=1.
  - cmd_ready_o = (level_o < g_fifo_depth).
  - A push while full is ignored; no reject_o.
  - A push with cmd_cycles_i >= g_cycles_per_sec is not stored and pulses reject_o in the next cycle.
- Time compare: 68-bit unsigned comparison of {tai, cycles}. Equality means on time.
- State machine:
  - IDLE: queue empty. Go to ARMED on the edge after an accepted push.
  - ARMED: head command visible (FWFT); compare it with the time sampled this cycle.
    - Time equal: at the edge, issue the command and pop it.
    - Time greater: late. Pulse late_o; late_cnt_o += 1, saturating at 0xFFFF. With g_late_policy=0, pop without a strobe; with 1, issue and pop.
    - Time less: hold.
    - After a pop: stay ARMED if the queue is non-empty, otherwise go to IDLE.
    - If tm_time_valid_i=0: go to HOLD; no compare or issue that cycle.
  - HOLD: no issue and no late detection. Return to ARMED on the edge where tm_time_valid_i=1, or to IDLE if the queue was flushed.
- Issue timing:
  - tune_stb_o and the tune_* data are registered, so the strobe is high in cycle k+1 for a match in cycle k. Latency is exactly 1 cycle.
  - tune_* data hold the last issued value between strobes.
- Spacing:
  - The next head is compared in the cycle after a pop, so commands on consecutive cycles are issued back-to-back.
  - A command pushed into an empty queue at edge k is first compared in cycle k+1.
- Ordering: no reordering. A head scheduled later blocks earlier-timestamped entries behind it; those entries are detected late when they reach the head.
- Flush:
  - flush_i=1 at an edge empties the queue, returns to IDLE and suppresses any issue or late pulse that edge.
  - A simultaneous push is dropped.
  - late_cnt_o is unaffected.
- Push and pop on the same edge: both happen; level_o is unchanged.
- Reset mid-operation: rst_i overrides everything, including a pending strobe, at that edge.

Test Plan:
- Simulation settings: g_cycles_per_sec=1250, tai=100.
- Push {tai=101, cyc=500, tune=12345, load=1, acc=0xDEADCAFEBABE} -> exactly one tune_stb_o, in the cycle after the time reads (101,500), carrying those values; late_o never pulses.
- Push commands at (102,10), (102,11), (102,12) -> three strobes on consecutive cycles in order; level_o returns to 0.
- Time at (105,0); push a command for (104,1249):
  - with g_late_policy=0 -> one late_o pulse, no strobe, late_cnt_o=1;
  - with g_late_policy=1 -> strobe in cycle +2 after the push, plus late_o.
- Push g_fifo_depth+1 commands for (200,0) -> cmd_ready_o low after 8 pushes and the 9th is ignored; flush_i -> level_o=0, no strobe at (200,0).
- Push cyc=1250 -> reject_o pulses, level_o stays 0. Drop tm_time_valid_i across target (110,100) and restore it at (110,300) -> no strobe during the drop; late detected on restore.
- Assert rst_i one cycle before a matching time -> no strobe; all outputs 0 and cmd_ready_o=1 on the next cycle.
